// File: rtl/console_pkg.sv
// Shared register offsets and clear-engine state encoding for the MMIO character console.
package console_pkg;

    localparam logic [31:0] OFF_CTRL    = 32'h0000_0000;
    localparam logic [31:0] OFF_STATUS  = 32'h0000_0004;
    localparam logic [31:0] OFF_CURSOR  = 32'h0000_0008;
    localparam logic [31:0] OFF_PUTC    = 32'h0000_000C;
    localparam logic [31:0] OFF_SW      = 32'h0000_0010;
    localparam logic [31:0] OFF_SW_EDGE = 32'h0000_0014;
    localparam logic [31:0] OFF_CHAR    = 32'h0000_0400;

    typedef enum logic {IDLE, CLEAR} clr_state_t;

endpackage

// File: rtl/mmio_char_console_if.sv
// CPU data-bus interface of the console: write strobe, address, write data, combinational read data.
interface mmio_char_console_if;
    logic        we;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output we, output address, output wdata, input rdata);
    modport slave  (input we, input address, input wdata, output rdata);
endinterface

// File: rtl/sw_sync_edge.sv
// Switch synchronisers followed by rising-edge detection into sticky write-1-to-clear flags.
module sw_sync_edge #(
    parameter int unsigned NSW         = 7,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NSW-1:0] sw,
    input  logic [NSW-1:0] clr,
    output logic [NSW-1:0] synced,
    output logic [NSW-1:0] edges
);

    logic [NSW-1:0] chain [SYNC_STAGES];
    logic [NSW-1:0] prev;

    assign synced = chain[SYNC_STAGES-1];

    // A fresh edge outranks a simultaneous clear so no event is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) chain[s] <= '0;
            prev  <= '0;
            edges <= '0;
        end else begin
            chain[0] <= sw;
            for (int s = 1; s < int'(SYNC_STAGES); s++) chain[s] <= chain[s-1];
            prev  <= chain[SYNC_STAGES-1];
            edges <= (edges & ~clr) | (chain[SYNC_STAGES-1] & ~prev);
        end
    end

endmodule

// File: rtl/mmio_char_console.sv
// Memory-mapped console: character buffer with cursor, hardware clear engine and switch capture.
module mmio_char_console
    import console_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned NSW         = 7,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  FILL_CHAR   = 8'h20
) (
    input  logic                 clk,
    input  logic                 reset,
    mmio_char_console_if.slave   bus,
    input  logic [NSW-1:0]       sw,
    output logic [DEPTH*8-1:0]   char_data,
    output logic                 busy
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [31:0] CHAR_END = OFF_CHAR + 32'(4 * DEPTH);

    clr_state_t      state, state_next;
    logic [AW-1:0]   idx;
    logic [AW-1:0]   cursor;
    logic [7:0]      mem [DEPTH];
    logic            clear_wr, clear_last;

    logic [31:0]     off, char_off;
    logic            is_char;
    logic [AW-1:0]   char_idx;
    logic            wr_ctrl, wr_cursor, wr_putc, wr_char, wr_edge;
    logic [NSW-1:0]  sw_synced, sw_edges, edge_clr;
    logic            unused_ok;

    // Word-granular decode relative to the window base.
    assign off       = {bus.address[31:2], 2'b00} - BASE_ADDR;
    assign char_off  = off - OFF_CHAR;
    assign is_char   = (off >= OFF_CHAR) && (off < CHAR_END);
    assign char_idx  = AW'(char_off >> 2);
    assign unused_ok = ^{bus.address[1:0], bus.wdata, char_off};

    assign wr_ctrl   = bus.we && (off == OFF_CTRL) && bus.wdata[0];
    assign wr_cursor = bus.we && (off == OFF_CURSOR);
    assign wr_putc   = bus.we && (off == OFF_PUTC);
    assign wr_char   = bus.we && is_char;
    assign wr_edge   = bus.we && (off == OFF_SW_EDGE);
    assign edge_clr  = wr_edge ? bus.wdata[NSW-1:0] : '0;

    sw_sync_edge #(
        .NSW         (NSW),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sw (
        .clk    (clk),
        .reset  (reset),
        .sw     (sw),
        .clr    (edge_clr),
        .synced (sw_synced),
        .edges  (sw_edges)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (wr_ctrl) state_next = CLEAR;
            CLEAR:   if (idx == AW'(DEPTH - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        clear_wr   = 1'b0;
        clear_last = 1'b0;
        if (state == CLEAR) begin
            busy       = 1'b1;
            clear_wr   = 1'b1;
            clear_last = (idx == AW'(DEPTH - 1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     idx <= '0;
        else if (busy) idx <= idx + AW'(1);
        else           idx <= '0;
    end

    // Bus writes to the buffer and cursor are ignored while the clear engine owns them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cursor <= '0;
        end else if (clear_last) begin
            cursor <= '0;
        end else if (!busy) begin
            if (wr_cursor)    cursor <= bus.wdata[AW-1:0];
            else if (wr_putc) cursor <= cursor + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= FILL_CHAR;
        end else if (clear_wr) begin
            mem[idx] <= FILL_CHAR;
        end else if (wr_char) begin
            mem[char_idx] <= bus.wdata[7:0];
        end else if (wr_putc) begin
            mem[cursor] <= bus.wdata[7:0];
        end
    end

    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_flat
        assign char_data[8*g +: 8] = mem[g];
    end

    always_comb begin
        bus.rdata = '0;
        if (is_char) begin
            bus.rdata = {24'b0, mem[char_idx]};
        end else begin
            case (off)
                OFF_STATUS:  bus.rdata = {15'b0, busy, 16'(cursor)};
                OFF_CURSOR:  bus.rdata = 32'(cursor);
                OFF_SW:      bus.rdata = 32'(sw_synced);
                OFF_SW_EDGE: bus.rdata = 32'(sw_edges);
                default:     bus.rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_char_console.sv
// Directed self-checking bench for mmio_char_console with hand-computed expectations.
module tb_mmio_char_console;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned NSW   = 7;

    localparam logic [31:0] A_CTRL    = BASE + 32'h00;
    localparam logic [31:0] A_STATUS  = BASE + 32'h04;
    localparam logic [31:0] A_CURSOR  = BASE + 32'h08;
    localparam logic [31:0] A_PUTC    = BASE + 32'h0C;
    localparam logic [31:0] A_SW      = BASE + 32'h10;
    localparam logic [31:0] A_SW_EDGE = BASE + 32'h14;
    localparam logic [31:0] A_CHAR    = BASE + 32'h400;

    logic                 clk;
    logic                 reset;
    logic [NSW-1:0]       sw;
    logic [DEPTH*8-1:0]   char_data;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    mmio_char_console_if bus ();

    mmio_char_console #(
        .BASE_ADDR   (BASE),
        .DEPTH       (DEPTH),
        .NSW         (NSW),
        .SYNC_STAGES (2),
        .FILL_CHAR   (8'h20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .sw        (sw),
        .char_data (char_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.we = 1'b1; bus.address = a; bus.wdata = d;
        @(negedge clk);
        bus.we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.address = a;
        #1 d = bus.rdata;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        int bad;
        rd(A_STATUS, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %h exp %h", d, 32'h0); end
        rd(A_CHAR + 32'd20, d);
        checks++; if (d !== 32'h20) begin errors++; $display("FAIL reset_entry5: got %h exp %h", d, 32'h20); end
        bad = 0;
        for (int i = 0; i < int'(DEPTH); i++) if (char_data[8*i +: 8] !== 8'h20) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL reset_char_data: %0d entries differ from exp 20", bad); end
    endtask

    task automatic test_putc_wrap;
        logic [31:0] d;
        wr(A_CURSOR, 32'd254);
        // three back-to-back PUTC cycles with we held high
        @(negedge clk); bus.we = 1'b1; bus.address = A_PUTC; bus.wdata = 32'h41;
        @(negedge clk); bus.wdata = 32'h42;
        @(negedge clk); bus.wdata = 32'h43;
        @(negedge clk); bus.we = 1'b0;
        rd(A_CHAR + 32'd4*254, d);
        checks++; if (d !== 32'h41) begin errors++; $display("FAIL putc_254: got %h exp %h", d, 32'h41); end
        rd(A_CHAR + 32'd4*255, d);
        checks++; if (d !== 32'h42) begin errors++; $display("FAIL putc_255: got %h exp %h", d, 32'h42); end
        rd(A_CHAR, d);
        checks++; if (d !== 32'h43) begin errors++; $display("FAIL putc_wrap_0: got %h exp %h", d, 32'h43); end
        rd(A_STATUS, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL putc_status: got %h exp %h", d, 32'h1); end
        rd(A_PUTC, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL putc_read: got %h exp %h", d, 32'h0); end
        checks++; if (char_data[8*255 +: 8] !== 8'h42) begin errors++; $display("FAIL putc_flat_255: got %h exp %h", char_data[8*255 +: 8], 8'h42); end
    endtask

    task automatic test_char_window;
        logic [31:0] d;
        wr(A_CHAR + 32'd28, 32'h0000_015A);
        rd(A_CHAR + 32'd28, d);
        checks++; if (d !== 32'h5A) begin errors++; $display("FAIL char_rw_7: got %h exp %h", d, 32'h5A); end
        checks++; if (char_data[63:56] !== 8'h5A) begin errors++; $display("FAIL char_flat_7: got %h exp %h", char_data[63:56], 8'h5A); end
        wr(A_CURSOR, 32'd300);
        rd(A_CURSOR, d);
        checks++; if (d !== 32'd44) begin errors++; $display("FAIL cursor_mod: got %0d exp %0d", d, 44); end
        wr(A_CURSOR, 32'd1);
    endtask

    task automatic test_clear;
        logic [31:0] d;
        int cnt, guard, bad;
        wr(A_CTRL, 32'h1);
        cnt = 0; guard = 0;
        while (busy === 1'b1 && guard < 2000) begin
            cnt++;
            if (cnt == 50) begin bus.we = 1'b1; bus.address = A_PUTC; bus.wdata = 32'h58; end
            else bus.we = 1'b0;
            if (cnt == 100) begin
                bus.address = A_STATUS;
                #1;
                checks++; if (bus.rdata !== 32'h0001_0001) begin errors++; $display("FAIL clear_status_mid: got %h exp %h", bus.rdata, 32'h0001_0001); end
            end
            @(negedge clk);
            guard++;
        end
        bus.we = 1'b0;
        checks++; if (cnt != int'(DEPTH)) begin errors++; $display("FAIL clear_busy_cycles: got %0d exp %0d", cnt, DEPTH); end
        bad = 0;
        for (int i = 0; i < int'(DEPTH); i++) if (char_data[8*i +: 8] !== 8'h20) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL clear_fill: %0d entries differ from exp 20", bad); end
        rd(A_STATUS, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL clear_status_end: got %h exp %h", d, 32'h0); end
    endtask

    task automatic test_switch;
        logic [31:0] d;
        int seen;
        @(negedge clk);
        #3 sw[3] = 1'b1;
        seen = 0;
        for (int i = 0; i < 3 && seen == 0; i++) begin
            rd(A_SW, d);
            if (d[3] === 1'b1) seen = 1;
        end
        checks++; if (seen != 1 || d !== 32'h08) begin errors++; $display("FAIL sw_sync: got %h exp %h", d, 32'h08); end
        rd(A_SW_EDGE, d);
        checks++; if (d !== 32'h08) begin errors++; $display("FAIL sw_edge_set: got %h exp %h", d, 32'h08); end
        wr(A_SW_EDGE, 32'h08);
        rd(A_SW_EDGE, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL sw_edge_w1c: got %h exp %h", d, 32'h0); end
        // drop the switch, then make the new edge land on the W1C cycle
        @(negedge clk); sw[3] = 1'b0;
        repeat (4) @(negedge clk);
        sw[3] = 1'b1;
        @(negedge clk);
        @(negedge clk); bus.we = 1'b1; bus.address = A_SW_EDGE; bus.wdata = 32'h08;
        @(negedge clk); bus.we = 1'b0;
        rd(A_SW_EDGE, d);
        checks++; if (d !== 32'h08) begin errors++; $display("FAIL sw_set_wins: got %h exp %h", d, 32'h08); end
        sw = '0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid_clear;
        logic [31:0] d;
        int bad;
        wr(A_CHAR + 32'd4*200, 32'h55);
        wr(A_CTRL, 32'h1);
        repeat (99) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b exp %b", busy, 1'b0); end
        bad = 0;
        for (int i = 0; i < int'(DEPTH); i++) if (char_data[8*i +: 8] !== 8'h20) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_mid_fill: %0d entries differ from exp 20", bad); end
        bus.address = A_SW_EDGE;
        #1;
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_edge: got %h exp %h", bus.rdata, 32'h0); end
        @(negedge clk); reset = 1'b0;
        wr(A_CURSOR, 32'd300);
        rd(A_CURSOR, d);
        checks++; if (d !== 32'd44) begin errors++; $display("FAIL rst_mid_cursor: got %0d exp %0d", d, 44); end
    endtask

    task automatic test_out_of_window;
        logic [31:0] d;
        int bad;
        wr(BASE - 32'd4, 32'h41);
        wr(BASE + 32'h800, 32'h41);
        rd(BASE - 32'd4, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL oow_below: got %h exp %h", d, 32'h0); end
        rd(BASE + 32'h800, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL oow_above: got %h exp %h", d, 32'h0); end
        rd(A_STATUS, d);
        checks++; if (d !== 32'd44) begin errors++; $display("FAIL oow_status: got %h exp %h", d, 32'd44); end
        bad = 0;
        for (int i = 0; i < int'(DEPTH); i++) if (char_data[8*i +: 8] !== 8'h20) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL oow_buffer: %0d entries differ from exp 20", bad); end
    endtask

    initial begin
        reset = 1'b1;
        sw = '0;
        bus.we = 1'b0; bus.address = '0; bus.wdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_putc_wrap();
        test_char_window();
        test_clear();
        test_switch();
        test_reset_mid_clear();
        test_out_of_window();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
